// File: rtl/line_pkg.sv
// Shared types for the beat-to-line assembler: beat count, slot index and FSM states.
package line_pkg;

  localparam int BEATS = 8;

  typedef logic [2:0] slot_idx_t;

  typedef enum logic [1:0] {IDLE, FILL, FULL} asm_state_t;

endpackage

// File: rtl/line_assembler8_demux8.sv
// 3->8 one-hot write-enable decoder; selects which line slot captures the current beat.
module demux8
  import line_pkg::*;
(
  input  logic      [2:0] sel,
  input  logic            en,
  output logic      [7:0] we
);

  always_comb begin
    we      = '0;
    we[sel] = en;
  end

endmodule

// File: rtl/line_assembler8.sv
// Collects 8 WIDTH-bit beats into one line, starting at slot start_sel and wrapping mod 8.
module line_assembler8
  import line_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           start_sel,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic [8*WIDTH-1:0]   line,
  output logic                 busy
);

  asm_state_t state;
  slot_idx_t  ptr;
  slot_idx_t  cnt;
  logic       beat;
  logic [7:0] we;

  assign in_ready   = (state == FILL);
  assign line_valid = (state == FULL);
  assign busy       = (state != IDLE);

  // abort takes priority over a beat presented in the same cycle
  assign beat = in_ready && in_valid && !abort;

  demux8 u_demux8 (
    .sel (ptr),
    .en  (beat),
    .we  (we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= start_sel;
            cnt   <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            ptr <= ptr + 3'd1;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= FULL;
          end
        end
        FULL: begin
          if (line_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (we[k]) line[k*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_line_assembler8.sv
// Randomized scoreboard bench for line_assembler8 with a slot-array reference model.
module tb_line_assembler8;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     start_sel = '0;
  logic           abort = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           line_valid;
  logic           line_ready = 1'b0;
  logic [8*W-1:0] line;
  logic           busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W-1:0]   mslot [8];
  int             mptr = 0;
  int             mcnt = 0;
  logic [8*W-1:0] exp_q [$];

  line_assembler8 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_sel  (start_sel),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line       (line),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [8*W-1:0] model_line();
    logic [8*W-1:0] ln;
    for (int k = 0; k < 8; k++) ln[k*W +: W] = mslot[k];
    return ln;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a line transfers on the edge following a negedge with valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && line_valid && line_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL line_unexpected: got %h expected none", line);
        end else begin
          chk("line_data", line, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_start(input logic [2:0] sel, input logic with_beat);
    start     = 1'b1;
    start_sel = sel;
    in_valid  = with_beat;
    in_data   = $urandom;
    chk("idle_in_ready", {255'd0, in_ready}, '0);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    mptr     = sel;
    mcnt     = 0;
    chk("fill_in_ready", {255'd0, in_ready}, 256'd1);
    chk("fill_busy", {255'd0, busy}, 256'd1);
  endtask

  task automatic do_beat(input logic [W-1:0] data, input logic valid, input logic ab,
                         input logic poke_start);
    in_valid = valid;
    in_data  = data;
    abort    = ab;
    start    = poke_start;
    start_sel = 3'($urandom);
    chk("beat_in_ready", {255'd0, in_ready}, 256'd1);
    chk("beat_line_valid", {255'd0, line_valid}, '0);
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    if (!ab && valid) begin
      mslot[mptr] = data;
      mptr = (mptr + 1) % 8;
      mcnt++;
      if (mcnt == 8) exp_q.push_back(model_line());
    end
  endtask

  task automatic do_fill(input logic [2:0] sel, input logic [W-1:0] base, input logic rnd,
                         input logic stall, input logic start_beat);
    int guard = 0;
    do_start(sel, start_beat);
    while (mcnt < 8 && guard < 64) begin
      logic v;
      logic [W-1:0] d;
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      d = rnd ? W'($urandom) : base + W'(mcnt);
      do_beat(d, v, 1'b0, guard == 2);
      guard++;
    end
    if (mcnt < 8) begin
      total_cnt++;
      $display("FAIL fill_budget: got %0d beats expected 8", mcnt);
    end
    chk("full_line_valid", {255'd0, line_valid}, 256'd1);
    chk("full_in_ready", {255'd0, in_ready}, '0);
  endtask

  task automatic drain(input int hold, input logic poke);
    logic [8*W-1:0] held;
    held = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int i = 0; i < hold; i++) begin
      line_ready = 1'b0;
      start      = poke;
      abort      = poke;
      tick();
      chk("hold_line_valid", {255'd0, line_valid}, 256'd1);
      chk("hold_line", line, held);
    end
    abort      = 1'b0;
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    start      = 1'b0;
    chk("drain_line_valid", {255'd0, line_valid}, '0);
    chk("drain_busy", {255'd0, busy}, '0);
    chk("drain_line_kept", line, held);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mslot[k] = '0;
    #2;
    chk("rst_line", line, '0);
    chk("rst_flags", {252'd0, in_ready, line_valid, busy, 1'b0}, '0);
    #20 rst_n = 1'b1;
    @(negedge clk);

    // linear fill, then wrap fill
    do_fill(3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    drain(0, 1'b0);
    do_fill(3'd5, 32'hA0, 1'b0, 1'b0, 1'b0);
    chk("wrap_slot0", {224'd0, line[0 +: W]}, 256'h0A3);
    chk("wrap_slot4", {224'd0, line[4*W +: W]}, 256'h0A7);
    drain(1, 1'b0);

    // stalls and backpressure, with start/abort poked while FULL
    do_fill(3'($urandom), '0, 1'b1, 1'b1, 1'b0);
    drain(5, 1'b1);

    // abort together with the 4th beat
    do_start(3'd6, 1'b0);
    for (int i = 0; i < 3; i++) do_beat(W'($urandom), 1'b1, 1'b0, 1'b0);
    do_beat(32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    chk("abort_busy", {255'd0, busy}, '0);
    chk("abort_in_ready", {255'd0, in_ready}, '0);
    do_fill(3'd2, '0, 1'b1, 1'b0, 1'b0);
    drain(2, 1'b0);

    // start with a simultaneous beat in IDLE
    do_fill(3'd3, 32'h50, 1'b0, 1'b0, 1'b1);
    chk("start_beat_slot3", {224'd0, line[3*W +: W]}, 256'h50);
    drain(0, 1'b0);

    // asynchronous reset mid-FILL
    do_start(3'd1, 1'b0);
    for (int i = 0; i < 3; i++) do_beat(W'($urandom) | 32'h1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_line", line, '0);
    chk("arst_flags", {252'd0, in_ready, line_valid, busy, 1'b0}, '0);
    for (int k = 0; k < 8; k++) mslot[k] = '0;
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_fill(3'd7, '0, 1'b1, 1'b1, 1'b0);
    drain(1, 1'b0);

    // a few random lines
    for (int n = 0; n < 6; n++) begin
      do_fill(3'($urandom), '0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (2) tick();
    chk("queue_empty", 256'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
